// File: rtl/dmem_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_lsu : byte-addressed load/store initiator for a word-wide RAM;         |
// |            lane placement, sign extension, word-crossing split.             |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+

package def;
    typedef struct packed {
        logic [29:0] ADDR;
        logic        WE;
        logic [3:0]  BE;
        logic [31:0] WD;
    } dmem_w;

    typedef struct packed {
        logic [31:0] RD;
    } dmem_r;
endpackage

module dmem_lsu (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WE,
    input  logic [1:0]  REQ_SIZE,
    input  logic        REQ_SIGNED,
    input  logic [31:0] REQ_ADDR,
    input  logic [31:0] REQ_WD,
    output logic        RSP_VALID,
    output logic        RSP_ST,
    output logic [31:0] RSP_RD,
    output def::dmem_w  DMEM_W,
    input  def::dmem_r  DMEM_R
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SPLIT_LD = 2'd1,
        S_SPLIT_ST = 2'd2,
        S_FIN      = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [29:0] r_word;
    logic [3:0]  r_hi_be;
    logic [31:0] r_hi_wd;
    logic [1:0]  r_k;
    logic [1:0]  r_size;
    logic        r_signed;
    logic        r_split;
    logic [31:0] r_low;
    logic        r_rsp_valid;
    logic        r_rsp_st;

    logic [3:0]  w_mask;
    logic [7:0]  w_be8;
    logic [63:0] w_wd64;
    logic        w_split;
    logic        w_accept;
    logic [63:0] w_data64;
    logic [31:0] w_lane;
    logic [31:0] w_ext;

    always_comb begin
        case (REQ_SIZE)
            2'd0:    w_mask = 4'b0001;
            2'd1:    w_mask = 4'b0011;
            default: w_mask = 4'b1111;
        endcase
    end

    // 8-lane view: lanes 7:4 belong to the following word when an access crosses
    assign w_be8   = {4'b0000, w_mask} << REQ_ADDR[1:0];
    assign w_wd64  = {32'h0, REQ_WD} << {REQ_ADDR[1:0], 3'b000};
    assign w_split = ((REQ_SIZE == 2'd1) && (REQ_ADDR[1:0] == 2'd3)) ||
                     (REQ_SIZE[1] && (REQ_ADDR[1:0] != 2'd0));

    assign REQ_READY = (r_state == S_IDLE) || (r_state == S_FIN);
    assign w_accept  = REQ_VALID && REQ_READY;

    always_comb begin
        w_state_nxt = r_state;
        DMEM_W.ADDR = REQ_ADDR[31:2];
        DMEM_W.WE   = 1'b0;
        DMEM_W.BE   = 4'b0000;
        DMEM_W.WD   = 32'h0;
        case (r_state)
            S_SPLIT_LD: begin
                DMEM_W.ADDR = r_word + 30'd1;
                w_state_nxt = S_FIN;
            end
            S_SPLIT_ST: begin
                DMEM_W.ADDR = r_word + 30'd1;
                DMEM_W.WE   = 1'b1;
                DMEM_W.BE   = r_hi_be;
                DMEM_W.WD   = r_hi_wd;
                w_state_nxt = S_FIN;
            end
            default: begin
                w_state_nxt = S_IDLE;
                if (w_accept) begin
                    // REQ_READY is high during reset, so the write strobe is gated here
                    DMEM_W.WE = REQ_WE & RESET_N;
                    if (REQ_WE) begin
                        DMEM_W.BE = w_be8[3:0];
                        DMEM_W.WD = w_wd64[31:0];
                    end
                    if (w_split)
                        w_state_nxt = REQ_WE ? S_SPLIT_ST : S_SPLIT_LD;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= S_IDLE;
            r_word      <= '0;
            r_hi_be     <= '0;
            r_hi_wd     <= '0;
            r_k         <= '0;
            r_size      <= '0;
            r_signed    <= 1'b0;
            r_split     <= 1'b0;
            r_low       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_st    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rsp_valid <= 1'b0;
            r_rsp_st    <= 1'b0;
            if (r_state == S_SPLIT_LD) begin
                r_low       <= DMEM_R.RD;
                r_rsp_valid <= 1'b1;
            end else if (r_state == S_SPLIT_ST) begin
                r_rsp_valid <= 1'b1;
                r_rsp_st    <= 1'b1;
            end else if (w_accept) begin
                r_word   <= REQ_ADDR[31:2];
                r_hi_be  <= w_be8[7:4];
                r_hi_wd  <= w_wd64[63:32];
                r_k      <= REQ_ADDR[1:0];
                r_size   <= REQ_SIZE;
                r_signed <= REQ_SIGNED;
                r_split  <= w_split;
                if (!w_split) begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_st    <= REQ_WE;
                end
            end
        end
    end

    // Read data arrives the cycle after the address, so the result is formed from registered control
    always_comb begin
        w_data64 = r_split ? {DMEM_R.RD, r_low} : {32'h0, DMEM_R.RD};
        w_lane   = w_data64[{r_k, 3'b000} +: 32];
        case (r_size)
            2'd0:    w_ext = {{24{r_signed & w_lane[7]}}, w_lane[7:0]};
            2'd1:    w_ext = {{16{r_signed & w_lane[15]}}, w_lane[15:0]};
            default: w_ext = w_lane;
        endcase
    end

    assign RSP_VALID = r_rsp_valid;
    assign RSP_ST    = r_rsp_st;
    assign RSP_RD    = (r_rsp_valid && !r_rsp_st) ? w_ext : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_dmem_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dmem_lsu : random and directed loads/stores against a byte-level model.  |
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+

module tb_dmem_lsu;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic        REQ_WE;
    logic [1:0]  REQ_SIZE;
    logic        REQ_SIGNED;
    logic [31:0] REQ_ADDR;
    logic [31:0] REQ_WD;
    logic        RSP_VALID;
    logic        RSP_ST;
    logic [31:0] RSP_RD;
    def::dmem_w  DMEM_W;
    def::dmem_r  DMEM_R;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    typedef struct {
        logic        st;
        logic [31:0] rd;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  rmem [logic [31:0]];
    logic [31:0] ram  [logic [29:0]];
    def::dmem_w  acc_w;
    int          acc_cyc;

    dmem_lsu u_dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .REQ_VALID  (REQ_VALID),
        .REQ_READY  (REQ_READY),
        .REQ_WE     (REQ_WE),
        .REQ_SIZE   (REQ_SIZE),
        .REQ_SIGNED (REQ_SIGNED),
        .REQ_ADDR   (REQ_ADDR),
        .REQ_WD     (REQ_WD),
        .RSP_VALID  (RSP_VALID),
        .RSP_ST     (RSP_ST),
        .RSP_RD     (RSP_RD),
        .DMEM_W     (DMEM_W),
        .DMEM_R     (DMEM_R)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Word RAM with byte enables and a registered read
    always @(posedge CLK) begin : g_ram
        logic [31:0] w;
        w = ram.exists(DMEM_W.ADDR) ? ram[DMEM_W.ADDR] : 32'h0;
        DMEM_R.RD <= w;
        if (DMEM_W.WE) begin
            for (int b = 0; b < 4; b++)
                if (DMEM_W.BE[b]) w[8*b +: 8] = DMEM_W.WD[8*b +: 8];
            ram[DMEM_W.ADDR] = w;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [7:0] rbyte(input logic [31:0] a);
        return rmem.exists(a) ? rmem[a] : 8'h00;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic sg);
        logic [31:0] v = 32'h0;
        int n = nbytes(sz);
        for (int i = 0; i < n; i++) v[8*i +: 8] = rbyte(a + 32'(i));
        if (sg)
            for (int j = 8 * n; j < 32; j++) v[j] = v[8*n-1];
        return v;
    endfunction

    function automatic bit crosses(input logic [31:0] a, input logic [1:0] sz);
        return (32'(a[1:0]) + nbytes(sz)) > 4;
    endfunction

    always @(negedge CLK) begin
        if (RESET_N === 1'b1 && RSP_VALID === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_latency", cyc, e.cyc);
                check("rsp_st", RSP_ST, e.st);
                check("rsp_rd", RSP_RD, e.rd);
            end
        end
    end

    // Called just after a rising edge; returns just after the edge following acceptance
    task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        bit got = 0;
        exp_t e;
        REQ_VALID  = 1'b1;
        REQ_WE     = we;
        REQ_SIZE   = sz;
        REQ_SIGNED = sg;
        REQ_ADDR   = a;
        REQ_WD     = wd;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge CLK);
            if (REQ_READY) begin
                got     = 1;
                acc_w   = DMEM_W;
                acc_cyc = cyc;
                e.st    = we;
                e.cyc   = cyc + (crosses(a, sz) ? 2 : 1);
                if (we) begin
                    for (int b = 0; b < nbytes(sz); b++) rmem[a + 32'(b)] = wd[8*b +: 8];
                    e.rd = 32'h0;
                end else begin
                    e.rd = ref_load(a, sz, sg);
                end
                exp_q.push_back(e);
            end
            @(posedge CLK);
            #1;
        end
        if (!got) check("req_ready_timeout", 0, 1);
        REQ_VALID = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        int c[4];
        logic [7:0] saved;
        RESET_N    = 1'b0;
        REQ_VALID  = 1'b1;
        REQ_WE     = 1'b1;
        REQ_SIZE   = 2'd2;
        REQ_SIGNED = 1'b0;
        REQ_ADDR   = 32'h100;
        REQ_WD     = 32'hFFFF_FFFF;
        @(negedge CLK);
        check("rst_ready", REQ_READY, 1);
        check("rst_rsp_valid", RSP_VALID, 0);
        check("rst_rsp_st", RSP_ST, 0);
        check("rst_rsp_rd", RSP_RD, 0);
        check("rst_we", DMEM_W.WE, 0);
        REQ_VALID = 1'b0;
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        idle(1);

        // store word then immediate load of the same word
        issue(1, 2'd2, 0, 32'h100, 32'h1122_3344);
        check("st100_we", acc_w.WE, 1);
        check("st100_be", acc_w.BE, 4'hF);
        check("st100_idx", acc_w.ADDR, 30'h40);
        check("st100_wd", acc_w.WD, 32'h1122_3344);
        issue(0, 2'd2, 0, 32'h100, 32'h0);
        check("ld100_we", acc_w.WE, 0);
        check("ld100_be", acc_w.BE, 4'h0);

        // sign/zero extension
        issue(1, 2'd2, 0, 32'h10, 32'h80FF_7F01);
        issue(0, 2'd0, 1, 32'h12, 32'h0);
        issue(0, 2'd0, 0, 32'h13, 32'h0);
        issue(0, 2'd1, 1, 32'h12, 32'h0);

        // word store crossing into the next word
        issue(1, 2'd2, 0, 32'h201, 32'hAABB_CCDD);
        check("st201_idx0", acc_w.ADDR, 30'h80);
        check("st201_be0", acc_w.BE, 4'b1110);
        check("st201_wd0", acc_w.WD, 32'hBBCC_DD00);
        @(negedge CLK);
        check("st201_we1", DMEM_W.WE, 1);
        check("st201_idx1", DMEM_W.ADDR, 30'h81);
        check("st201_be1", DMEM_W.BE, 4'b0001);
        check("st201_wd1", DMEM_W.WD, 32'h0000_00AA);
        check("st201_ready1", REQ_READY, 0);
        @(posedge CLK);
        #1;

        // split loads
        issue(1, 2'd2, 0, 32'h300, 32'h4433_2211);
        issue(1, 2'd2, 0, 32'h304, 32'h8877_6655);
        issue(0, 2'd1, 0, 32'h303, 32'h0);
        issue(0, 2'd2, 0, 32'h302, 32'h0);

        // back-to-back aligned loads
        for (int i = 0; i < 4; i++) begin
            issue(0, 2'd2, 0, 32'h300 + 32'(4 * (i % 2)), 32'h0);
            c[i] = acc_cyc;
        end
        for (int i = 1; i < 4; i++) check("b2b_gap", c[i] - c[i-1], 1);

        // address wrap across the top of memory
        issue(1, 2'd1, 0, 32'hFFFF_FFFF, 32'h0000_BEEF);
        issue(0, 2'd2, 0, 32'hFFFF_FFFE, 32'h0);
        issue(0, 2'd1, 1, 32'hFFFF_FFFF, 32'h0);

        // reset while the second half of a split store is pending
        issue(1, 2'd2, 0, 32'h400, 32'h1357_9BDF);
        issue(1, 2'd2, 0, 32'h404, 32'h5A5A_5A5A);
        idle(3);
        saved = rbyte(32'h404);
        issue(1, 2'd2, 0, 32'h401, 32'hDEAD_BEEF);
        RESET_N = 1'b0;
        exp_q.delete();
        rmem[32'h404] = saved;
        @(negedge CLK);
        check("abort_we", DMEM_W.WE, 0);
        check("abort_rsp_valid", RSP_VALID, 0);
        check("abort_ready", REQ_READY, 1);
        @(negedge CLK);
        check("abort_rsp_valid2", RSP_VALID, 0);
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        idle(1);
        issue(0, 2'd2, 0, 32'h404, 32'h0);
        issue(0, 2'd2, 0, 32'h400, 32'h0);

        // randomized traffic near both ends of the address space
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 63))
                                            : 32'hFFFF_FFC0 + 32'($urandom_range(0, 63));
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), a, $urandom);
            if ($urandom_range(0, 3) == 0) idle(1);
        end

        idle(4);
        check("rsp_pending", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
